// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width helper and Gray/binary conversions shared by the
// read-side and write-side FIFO control blocks.
package fifo_pkg;

  // Pointer width is one bit wider than the address so laps can be told apart.
  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

  // Binary to Gray; zero-extended inputs stay valid for any narrower width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB down; upper zero bits are harmless.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter for the synchronized write pointer.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [31:0] bin_full;

  // Convert at full width, then keep the pointer-width slice.
  always_comb begin
    bin_full = fifo_pkg::gray2bin(32'(gray_i));
    bin_o    = bin_full[W-1:0];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain control of an async FIFO. Keeps the binary/Gray
// read pointer, and registers empty, almost-empty, occupancy and underflow.
// Optional macro FIFO_RD_UNDERFLOW_EN enables the sticky underflow flag;
// without it runderflow is a constant 0.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);

  localparam int PW = ptr_width(ASIZE);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rgray_d;
  logic [PW-1:0] rlevel_q, level_d;
  logic [PW-1:0] wbin;
  logic [31:0]   gray_full;
  logic          rempty_q, rae_q;
  logic          rd_accept;

  gray2bin #(.W(PW)) u_wptr_g2b (
    .gray_i (rq2_wptr),
    .bin_o  (wbin)
  );

  // Next pointer, Gray pointer, and occupancy seen after this edge's read.
  always_comb begin
    rd_accept = rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(rd_accept);
    gray_full = bin2gray(32'(rbin_d));
    rgray_d   = gray_full[PW-1:0];
    level_d   = wbin - rbin_d;
  end

  // Pointer and flag registers, all loaded on the same edge.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= (rgray_d == rq2_wptr);
      rae_q    <= (32'(level_d) <= AE_THRESH);
      rlevel_q <= level_d;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic runderflow_q;

  // Sticky: any read request against an empty FIFO latches until reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else if (rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign runderflow = runderflow_q;
`else
  assign runderflow = 1'b0;
`endif

  assign rptr          = rptr_q;
  assign raddr         = rbin_q[ASIZE-1:0];
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 4, meaning log2 of FIFO depth (depth 16).
REQ-002 SHALL have parameter AE_THRESH, default 2, meaning almost-empty level threshold in words.
REQ-003 SHALL have port rclk, input, 1, read-domain clock; the block has this one clock only.
REQ-004 SHALL have port rrst, input, 1, reset; synchronous to rclk and active-high.
REQ-005 SHALL have port rinc, input, 1, read request.
REQ-006 SHALL have port rq2_wptr, input, ASIZE+1, Gray write pointer already synchronized into rclk.
REQ-007 SHALL have port rptr, output, ASIZE+1, registered Gray read pointer sent to the write domain.
REQ-008 SHALL have port raddr, output, ASIZE, binary read address to the RAM.
REQ-009 SHALL have port rempty, output, 1, registered empty flag.
REQ-010 SHALL have port ralmost_empty, output, 1, registered almost-empty flag.
REQ-011 SHALL have port rlevel, output, ASIZE+1, registered occupancy in words.
REQ-012 SHALL have port runderflow, output, 1, sticky underflow flag.

Function
REQ-013 SHALL keep a binary read counter rbin, ASIZE+1 bits; raddr = rbin[ASIZE-1:0], driven from the register.
REQ-014 SHALL accept a read only when rinc=1 and rempty=0; rbin_next = rbin + accepted.
REQ-015 SHALL compute rgray_next = (rbin_next >> 1) XOR rbin_next and register it to rptr in the same edge as rbin.
REQ-016 SHALL register rempty <= (rgray_next == rq2_wptr), one rclk latency.
REQ-017 SHALL convert rq2_wptr to binary wbin and register rlevel <= (wbin - rbin_next) mod 2^(ASIZE+1).
REQ-018 SHALL register ralmost_empty <= (level_next <= AE_THRESH), where level_next is the value loaded into rlevel.
REQ-019 SHALL ignore rinc while rempty=1: rbin, rptr and raddr stay unchanged.
REQ-020 SHALL wrap rbin from 2^(ASIZE+1)-1 to 0; the MSB toggle distinguishes laps.
REQ-021 SHALL use both the new rq2_wptr and the accepted read when they occur in the same cycle.
REQ-022 SHALL make the last word read (level 1, accepted read, no write) set rempty on the next edge.
REQ-023 SHALL let rlevel range only 0..2^ASIZE, with no saturation logic.

Reset
REQ-024 SHALL on rrst=1 at a rising rclk set rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
REQ-025 SHALL let reset override any concurrent rinc or rq2_wptr change; a read in the reset cycle is dropped.

Configuration
REQ-026 SHALL, with macro FIFO_RD_UNDERFLOW_EN defined, set runderflow on any edge where rinc=1 and rempty=1, holding it until rrst.
REQ-027 SHALL, without FIFO_RD_UNDERFLOW_EN, tie runderflow to constant 0 with no flop inferred.

Structure
REQ-028 SHALL take the Gray/binary conversion functions and the pointer-width constant (ASIZE+1) from shared package fifo_pkg, which the write-side control block also uses.
REQ-029 SHALL instantiate one combinational sub-module gray2bin for rq2_wptr conversion; all other logic stays in fifo_rd_ctrl.

Verification (ASIZE=4, AE_THRESH=2)
REQ-030 SHALL cover: reset release with rq2_wptr=0 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0.
REQ-031 SHALL cover: rq2_wptr 0 -> Gray(3)=5'b00010 -> rempty=0 and rlevel=3 one edge later, ralmost_empty=0.
REQ-032 SHALL cover: level 3, three rinc pulses -> raddr steps 0,1,2 -> rempty=1 on the edge after the third read, rptr=Gray(3).
REQ-033 SHALL cover: 40 write/read pairs -> rbin wraps past 31; rptr MSB toggles at 16 and 32; rempty never false-asserts.
REQ-034 SHALL cover: rinc=1 while empty -> pointers frozen; runderflow=1 with FIFO_RD_UNDERFLOW_EN, 0 without.
REQ-035 SHALL cover: level 16 (rq2_wptr=Gray(16), rbin=0) with read in the same cycle as a write -> rlevel stays 16, ralmost_empty=0; rrst mid-stream -> all outputs return to reset values next edge.
